// File: rtl/clk_div_measure.sv
// clk_div_measure: measures the period and high time of a divided clock (sig_in)
// in clk_in cycles, flags 50% duty, detects a stable period (locked) and a
// missing edge (err_overflow).
// Ports:
//   clk_in       - measurement clock
//   rst_n        - asynchronous active-low reset
//   sig_in       - divided clock under test, sampled as data
//   period       - clk_in cycles between the last two sig_in rising edges
//   high_time    - clk_in cycles sig_in was high within that period
//   valid        - one-cycle pulse when period/high_time/even update
//   even         - period is even and high_time is exactly half of it
//   locked       - LOCK_CNT consecutive equal periods seen
//   err_overflow - sticky: no rising edge within 2^CNT_W-1 cycles
// Build option: define CLK_DIV_MEASURE_SYNC_EN to add a 2-flop synchronizer on
// sig_in (for asynchronous sources). Measured values are unchanged; valid
// arrives 2 cycles later.
module clk_div_measure #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             even,
  output logic             locked,
  output logic             err_overflow
);

  localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_1 = MW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t          state;
  logic            sig_s;
  logic            sig_d;
  logic            rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] prev_period;
  logic            have_prev;
  logic [MW-1:0]   match_cnt;
  logic [MW-1:0]   match_nxt;
  logic            even_nxt;

`ifdef CLK_DIV_MEASURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sig_in};
    end
  end

  assign sig_s = sync_q[1];
`else
  // sig_in is assumed synchronous to clk_in in this build.
  assign sig_s = sig_in;
`endif

  assign rise = sig_s & ~sig_d;

  // On a capturing edge, cnt is the completed period and hcnt its high time.
  assign even_nxt = (cnt[0] == 1'b0) && (hcnt == (cnt >> 1));

  // The very first capture only seeds prev_period; later captures compare.
  always_comb begin
    match_nxt = match_cnt;
    if (!have_prev) begin
      match_nxt = '0;
    end else if (cnt == prev_period) begin
      if (match_cnt != LOCK_V) begin
        match_nxt = match_cnt + MATCH_1;
      end
    end else begin
      match_nxt = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sig_d        <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      prev_period  <= '0;
      have_prev    <= 1'b0;
      match_cnt    <= '0;
      period       <= '0;
      high_time    <= '0;
      valid        <= 1'b0;
      even         <= 1'b0;
      locked       <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      sig_d <= sig_s;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= ARM;
            cnt   <= CNT_ONE;
            hcnt  <= CNT_ONE;
          end
        end
        ARM, MEASURE: begin
          if (rise) begin
            // ARM interval may be partial, so only MEASURE edges report.
            state <= MEASURE;
            cnt   <= CNT_ONE;
            hcnt  <= CNT_ONE;
            if (state == MEASURE) begin
              period      <= cnt;
              high_time   <= hcnt;
              even        <= even_nxt;
              valid       <= 1'b1;
              prev_period <= cnt;
              have_prev   <= 1'b1;
              match_cnt   <= match_nxt;
              locked      <= (match_nxt == LOCK_V);
            end
          end else if (cnt == CNT_MAX) begin
            // No edge within counter range: restart from scratch, keep outputs.
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            err_overflow <= 1'b1;
            locked       <= 1'b0;
            match_cnt    <= '0;
            have_prev    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (sig_s) begin
              hcnt <= hcnt + CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_measure.sv
// Testbench for clk_div_measure: drives periodic sig_in waveforms, pushes the
// expected measurement for every completed period onto a scoreboard, and
// compares each valid pulse against it.
module tb_clk_div_measure;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 3;
  localparam int OVF_GAP  = 1 << CNT_W;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             even;
  logic             locked;
  logic             err_overflow;

  clk_div_measure #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .period      (period),
    .high_time   (high_time),
    .valid       (valid),
    .even        (even),
    .locked      (locked),
    .err_overflow(err_overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int p;
    int h;
    bit ev;
    bit lk;
    bit er;
    bit first;
  } exp_t;

  exp_t sb[$];

  // Stimulus-side model state
  int arm_rises = 0;
  bit pend_vld  = 1'b0;
  int pend_p    = 0;
  int pend_h    = 0;
  bit have      = 1'b0;
  int prev_p    = 0;
  int match     = 0;
  bit err_exp   = 1'b0;

  function automatic void push_exp(input int p, input int h);
    exp_t e;
    e.p     = p;
    e.h     = h;
    e.ev    = ((p % 2) == 0) && (h == p / 2);
    e.first = !have;
    if (!have) begin
      have  = 1'b1;
      match = 0;
    end else if (p == prev_p) begin
      if (match < LOCK_CNT) match++;
    end else begin
      match = 0;
    end
    prev_p = p;
    e.lk   = (match == LOCK_CNT);
    e.er   = err_exp;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    arm_rises = 0;
    pend_vld  = 1'b0;
    have      = 1'b0;
    match     = 0;
  endfunction

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      sig_in = v;
    end
  endtask

  // One period starting with a rising edge: h cycles high, p-h cycles low.
  task automatic start_period(input int p, input int h);
    if (arm_rises >= 2 && pend_vld) push_exp(pend_p, pend_h);
    if (arm_rises < 2) arm_rises++;
    pend_vld = 1'b1;
    pend_p   = p;
    pend_h   = h;
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic run_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) start_period(p, h);
  endtask

  task automatic hold_low(input int n);
    drive(1'b0, n);
    if (arm_rises >= 1 && pend_vld) begin
      if (pend_p + n >= OVF_GAP) begin
        model_reset();
        err_exp = 1'b1;
      end else begin
        pend_p += n;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"},    32'(period),       0);
    chk({tag, "_high_time"}, 32'(high_time),    0);
    chk({tag, "_valid"},     32'(valid),        0);
    chk({tag, "_even"},      32'(even),         0);
    chk({tag, "_locked"},    32'(locked),       0);
    chk({tag, "_err"},       32'(err_overflow), 0);
  endtask

  // Output monitor: compare each valid pulse against the scoreboard head.
  int   cyc = 0;
  int   last_vcyc = 0;
  exp_t mon_e;

  always @(negedge clk_in) begin
    cyc++;
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("period",    32'(period),       32'(mon_e.p));
        chk("high_time", 32'(high_time),    32'(mon_e.h));
        chk("even",      32'(even),         32'(mon_e.ev));
        chk("locked",    32'(locked),       32'(mon_e.lk));
        chk("err",       32'(err_overflow), 32'(mon_e.er));
        if (!mon_e.first) chk("valid_gap", 32'(cyc - last_vcyc), 32'(mon_e.p));
        last_vcyc = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_zero("reset");
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;

    run_wave(2, 1, 8);   // divide-by-2, locks on 4th valid
    run_wave(8, 4, 5);   // divide-by-8, 50% duty
    run_wave(6, 2, 5);   // period 6, 2 high: odd duty
    run_wave(4, 2, 6);   // divide-by-4 until locked
    run_wave(8, 4, 5);   // switch to 8: unlock then relock
    @(negedge clk_in);
    chk("locked_before_ovf", 32'(locked), 32'd1);

    hold_low(300);
    @(negedge clk_in);
    chk("ovf_err",    32'(err_overflow), 32'd1);
    chk("ovf_locked", 32'(locked),       32'd0);

    run_wave(4, 2, 6);   // resume: first intervals discarded
    hold_low(2);
    @(negedge clk_in);
    chk("err_sticky",     32'(err_overflow), 32'd1);
    chk("relock_after_ovf", 32'(locked),     32'(match == LOCK_CNT));

    // Asynchronous reset in the middle of a period
    @(posedge clk_in);
    #3;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    check_zero("midrst");
    chk("sb_empty_at_rst", 32'(sb.size()), 32'd0);
    sb.delete();
    model_reset();
    err_exp = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;

    run_wave(6, 2, 5);
    hold_low(6);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_measure.md
CLK_DIV_MEASURE -- requirements
Module: clk_div_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the period and high-time counters.
REQ-002 SHALL have parameter LOCK_CNT, default 3, the number of consecutive equal periods needed to assert locked.
REQ-003 SHALL have port clk_in, input, 1, measurement clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port sig_in, input, 1, divided clock under test, treated as a data signal.
REQ-006 SHALL have port period, output, CNT_W, clk_in cycles between consecutive sig_in rising edges.
REQ-007 SHALL have port high_time, output, CNT_W, clk_in cycles sig_in sampled high within the last period.
REQ-008 SHALL have port valid, output, 1, one-cycle pulse when period/high_time/even update.
REQ-009 SHALL have port even, output, 1, set when period is even and high_time equals period/2.
REQ-010 SHALL have port locked, output, 1, set when LOCK_CNT consecutive equal periods have been seen.
REQ-011 SHALL have port err_overflow, output, 1, sticky flag: no rising edge seen within the counter range.

Function
REQ-012 SHALL sample sig_in into register sig_d; rise SHALL be sig_s & ~sig_d, where sig_s is the sampled input (see Configuration).
REQ-013 SHALL implement FSM states IDLE, ARM, MEASURE; IDLE -> ARM on rise; ARM -> MEASURE on rise; MEASURE stays on rise.
REQ-014 SHALL discard the ARM interval (no valid) so that a partial first period after reset or overflow is never reported.
REQ-015 SHALL, in ARM/MEASURE, set cnt <= 1 on rise, otherwise cnt <= cnt+1; on rise in MEASURE, period <= cnt.
REQ-016 SHALL set hcnt <= 1 on rise, hcnt <= hcnt+1 when sig_s=1 without rise, otherwise hold; on rise in MEASURE, high_time <= hcnt.
REQ-017 SHALL assert valid for exactly the one cycle after each rise cycle in MEASURE; outputs are registered and hold between updates.
REQ-018 SHALL compute even from the newly captured values: period[0]==0 and high_time==period>>1.
REQ-019 SHALL increment a match counter (saturating at LOCK_CNT) when a new period equals the previous period, and clear it on mismatch; locked=1 iff match counter==LOCK_CNT; the first MEASURE capture SHALL only load the compare register.
REQ-020 SHALL, when cnt==2^CNT_W-1 in ARM/MEASURE with no rise: set err_overflow, clear locked and the match counter, return to IDLE; period/high_time hold.
REQ-021 SHALL have a minimum legal period of 2 (divide-by-2); a rise on every clk_in cycle is impossible by construction.

Reset
REQ-022 SHALL, while rst_n=0, immediately force the FSM to IDLE and set cnt, hcnt, sync/edge registers, period, high_time, valid, even, locked, err_overflow and the match counter to 0.
REQ-023 SHALL clear err_overflow only by reset.

Configuration
REQ-024 SHALL, with macro CLK_DIV_MEASURE_SYNC_EN defined, pass sig_in through a 2-flop synchronizer to form sig_s, adding 2 cycles of latency from sig_in to valid.
REQ-025 SHALL, without CLK_DIV_MEASURE_SYNC_EN, use sig_in directly as sig_s, for sig_in synchronous to clk_in; measured values SHALL be identical in both builds, only latency differs.

Verification
REQ-026 SHALL check: divide-by-2 from reset -> valid every 2 cycles, period=2, high_time=1, even=1, locked=1 from the 4th valid onward.
REQ-027 SHALL check: divide-by-8 at 50% duty -> period=8, high_time=4, even=1.
REQ-028 SHALL check: period 6 with 2 cycles high -> period=6, high_time=2, even=0.
REQ-029 SHALL check: while locked, switch from divide-4 to divide-8 -> first period=8 valid clears locked; locked returns after 3 further matching periods.
REQ-030 SHALL check: sig_in held low for 300 cycles -> err_overflow=1 and locked=0 at cnt=255; on resumed divide-4, the first period is discarded, then period=4 and err_overflow stays 1.
REQ-031 SHALL check: rst_n pulsed low in mid-period -> all outputs 0 in the same cycle; after release, the first interval is discarded before valid.
